// File: rtl/sys_bus_decoder.sv
// Core-to-peripheral bus decoder: address decode, one-hot slot request, stall handshake,
// timeout and bus-error reporting.
// Optional sticky error-cause capture is compiled in with `define SYS_BUS_ERR_CAUSE_EN.
module sys_bus_decoder #(
  parameter int unsigned             N_SLV     = 4,
  parameter logic [N_SLV*8-1:0]      DEV_CODES = {8'h04, 8'h03, 8'h02, 8'h00},
  parameter int unsigned             TIMEOUT   = 255
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [2:0]            core_size_i,
  input  logic [31:0]           core_addr_i,
  input  logic [31:0]           core_wd_i,
  output logic [31:0]           core_rd_o,
  output logic                  core_stall_o,
  output logic                  bus_err_o,
  output logic [N_SLV-1:0]      slv_req_o,
  output logic                  slv_we_o,
  output logic [2:0]            slv_size_o,
  output logic [31:0]           slv_addr_o,
  output logic [31:0]           slv_wd_o,
  input  logic [N_SLV*32-1:0]   slv_rd_i,
`ifdef SYS_BUS_ERR_CAUSE_EN
  input  logic                  err_clr_i,
  output logic [1:0]            err_cause_o,
  output logic [31:0]           err_addr_o,
`endif
  input  logic [N_SLV-1:0]      slv_ready_i
);

  localparam int unsigned SelW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [N_SLV-1:0]  slv_req_q, slv_req_d;
  logic              slv_we_q, slv_we_d;
  logic [2:0]        slv_size_q, slv_size_d;
  logic [31:0]       slv_addr_q, slv_addr_d;
  logic [31:0]       slv_wd_q, slv_wd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rd_q, rd_d;
  logic              err_q, err_d;

  logic              hit_any;
  logic [SelW-1:0]   hit_idx;
  logic              ready_sel;
  logic [31:0]       rd_sel;

  // Address decode: scan downwards so the lowest matching slot index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if (core_addr_i[31:24] == DEV_CODES[8*i +: 8]) begin
        hit_any = 1'b1;
        hit_idx = SelW'(i);
      end
    end
  end

  // Only the selected slot's ready/data are ever looked at.
  assign ready_sel = slv_ready_i[sel_q];
  assign rd_sel    = slv_rd_i[32*sel_q +: 32];

  // State and latched transaction registers.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      slv_req_q  <= '0;
      slv_we_q   <= 1'b0;
      slv_size_q <= '0;
      slv_addr_q <= '0;
      slv_wd_q   <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      slv_req_q  <= slv_req_d;
      slv_we_q   <= slv_we_d;
      slv_size_q <= slv_size_d;
      slv_addr_q <= slv_addr_d;
      slv_wd_q   <= slv_wd_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: decode in IDLE, wait for ready or timeout, one DONE cycle back to core.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    slv_req_d  = slv_req_q;
    slv_we_d   = slv_we_q;
    slv_size_d = slv_size_q;
    slv_addr_d = slv_addr_q;
    slv_wd_d   = slv_wd_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (core_req_i) begin
          if (hit_any) begin
            sel_d      = hit_idx;
            slv_req_d  = N_SLV'(1) << hit_idx;
            slv_we_d   = core_we_i;
            slv_size_d = core_size_i;
            slv_addr_d = core_addr_i;
            slv_wd_d   = core_wd_i;
            cnt_d      = '0;
            err_d      = 1'b0;
            state_d    = StWait;
          end else begin
            // Unmapped: finish immediately with an error, no slot is touched.
            rd_d    = '0;
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StWait: begin
        if (ready_sel) begin
          // Ready takes priority over a coincident timeout.
          rd_d      = slv_we_q ? 32'd0 : rd_sel;
          err_d     = 1'b0;
          slv_req_d = '0;
          cnt_d     = '0;
          state_d   = StDone;
        end else if (cnt_q == CntLast) begin
          rd_d      = '0;
          err_d     = 1'b1;
          slv_req_d = '0;
          cnt_d     = '0;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Core-side outputs: stall follows the request in IDLE, result only visible in DONE.
  always_comb begin
    core_stall_o = 1'b0;
    core_rd_o    = '0;
    bus_err_o    = 1'b0;
    unique case (state_q)
      StIdle: core_stall_o = core_req_i;
      StWait: core_stall_o = 1'b1;
      StDone: begin
        core_rd_o = rd_q;
        bus_err_o = err_q;
      end
      default: ;
    endcase
  end

  assign slv_req_o  = slv_req_q;
  assign slv_we_o   = slv_we_q;
  assign slv_size_o = slv_size_q;
  assign slv_addr_o = slv_addr_q;
  assign slv_wd_o   = slv_wd_q;

`ifdef SYS_BUS_ERR_CAUSE_EN
  logic [1:0]  err_cause_q;
  logic [31:0] err_addr_q;
  logic        unmapped_evt;
  logic        timeout_evt;

  // Error events coincide with the transition into DONE.
  assign unmapped_evt = (state_q == StIdle) && core_req_i && !hit_any;
  assign timeout_evt  = (state_q == StWait) && !ready_sel && (cnt_q == CntLast);

  // Sticky first-error capture; an error arriving with clear wins over the clear.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      err_cause_q <= 2'd0;
      err_addr_q  <= '0;
    end else if ((unmapped_evt || timeout_evt) && ((err_cause_q == 2'd0) || err_clr_i)) begin
      err_cause_q <= unmapped_evt ? 2'd1 : 2'd2;
      err_addr_q  <= unmapped_evt ? core_addr_i : slv_addr_q;
    end else if (err_clr_i) begin
      err_cause_q <= 2'd0;
      err_addr_q  <= '0;
    end
  end

  assign err_cause_o = err_cause_q;
  assign err_addr_o  = err_addr_q;
`endif

endmodule

// File: tb/tb_sys_bus_decoder.sv
// Self-checking bench for sys_bus_decoder: directed scenarios followed by random transactions,
// each compared against a transaction-level reference model.
module tb_sys_bus_decoder;

  localparam int unsigned N    = 4;
  localparam logic [31:0] DEVC = {8'h04, 8'h03, 8'h02, 8'h00};
  localparam int          TMO  = 8;

  logic            clk;
  logic            resetn;
  logic            core_req;
  logic            core_we;
  logic [2:0]      core_size;
  logic [31:0]     core_addr;
  logic [31:0]     core_wd;
  logic [31:0]     core_rd_o;
  logic            core_stall_o;
  logic            bus_err_o;
  logic [N-1:0]    slv_req_o;
  logic            slv_we_o;
  logic [2:0]      slv_size_o;
  logic [31:0]     slv_addr_o;
  logic [31:0]     slv_wd_o;
  logic [N*32-1:0] slv_rd;
  logic [N-1:0]    slv_ready;
`ifdef SYS_BUS_ERR_CAUSE_EN
  logic            err_clr;
  logic [1:0]      err_cause_o;
  logic [31:0]     err_addr_o;
  logic [1:0]      model_cause;
  logic [31:0]     model_addr;
`endif

  int checks = 0;
  int errors = 0;

  sys_bus_decoder #(
    .N_SLV    (N),
    .DEV_CODES(DEVC),
    .TIMEOUT  (TMO)
  ) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .core_req_i  (core_req),
    .core_we_i   (core_we),
    .core_size_i (core_size),
    .core_addr_i (core_addr),
    .core_wd_i   (core_wd),
    .core_rd_o   (core_rd_o),
    .core_stall_o(core_stall_o),
    .bus_err_o   (bus_err_o),
    .slv_req_o   (slv_req_o),
    .slv_we_o    (slv_we_o),
    .slv_size_o  (slv_size_o),
    .slv_addr_o  (slv_addr_o),
    .slv_wd_o    (slv_wd_o),
    .slv_rd_i    (slv_rd),
`ifdef SYS_BUS_ERR_CAUSE_EN
    .err_clr_i   (err_clr),
    .err_cause_o (err_cause_o),
    .err_addr_o  (err_addr_o),
`endif
    .slv_ready_i (slv_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode: lowest slot whose code equals the top address byte, -1 if none.
  function automatic int slot_of(input logic [31:0] addr);
    logic [31:0] codes;
    codes = DEVC;
    for (int i = 0; i < int'(N); i++) begin
      if (addr[31:24] == codes[8*i +: 8]) return i;
    end
    return -1;
  endfunction

  // One core transaction. delay = WAIT cycle (0 = first) on which the slot answers, -1 = never.
  task automatic txn(input logic [31:0] addr, input logic we, input logic [2:0] size,
                     input logic [31:0] wd, input int delay, input logic [31:0] data,
                     input logic noise_all);
    int              slot;
    int              exp_stall;
    logic            exp_err;
    logic [31:0]     exp_rd;
    int              stall_cnt;
    bit              done;
    logic [N-1:0]    rdy;
    logic [N*32-1:0] rdbus;

    slot = slot_of(addr);
    if (slot < 0) begin
      exp_stall = 1; exp_err = 1'b1; exp_rd = '0;
    end else if (delay >= 0 && delay < TMO) begin
      exp_stall = delay + 2; exp_err = 1'b0; exp_rd = we ? 32'd0 : data;
    end else begin
      exp_stall = TMO + 1; exp_err = 1'b1; exp_rd = '0;
    end

    @(negedge clk);
    core_req = 1'b1; core_addr = addr; core_we = we; core_size = size; core_wd = wd;
    slv_ready = '0;
    #1;
    check("idle_stall", 64'(core_stall_o), 64'd1);
    check("idle_no_req", 64'(slv_req_o), 64'd0);
    stall_cnt = 1;
    done = 0;

    for (int k = 0; k <= TMO + 4 && !done; k++) begin
      @(negedge clk);
      // Core side changes freely while stalled; the DUT must ignore it.
      core_req = 1'b0; core_addr = $urandom; core_we = 1'($urandom);
      core_wd = $urandom; core_size = 3'($urandom);
      rdy = noise_all ? '1 : N'($urandom);
      for (int i = 0; i < int'(N); i++) rdbus[32*i +: 32] = $urandom;
      if (slot >= 0) begin
        rdy[slot] = (k == delay);
        rdbus[32*slot +: 32] = data;
      end
      slv_ready = rdy; slv_rd = rdbus;
      #1;
      if (core_stall_o) begin
        stall_cnt++;
        if (k == 0 && slot >= 0) begin
          check("slv_req_onehot", 64'(slv_req_o), 64'(1 << slot));
          check("slv_addr", 64'(slv_addr_o), 64'(addr));
          check("slv_we", 64'(slv_we_o), 64'(we));
          check("slv_size", 64'(slv_size_o), 64'(size));
          check("slv_wd", 64'(slv_wd_o), 64'(wd));
        end
        check("wait_rd_zero", 64'(core_rd_o), 64'd0);
        check("wait_no_err", 64'(bus_err_o), 64'd0);
      end else begin
        done = 1;
        check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
        check("done_rd", 64'(core_rd_o), 64'(exp_rd));
        check("done_err", 64'(bus_err_o), 64'(exp_err));
        check("done_req_drop", 64'(slv_req_o), 64'd0);
`ifdef SYS_BUS_ERR_CAUSE_EN
        if (exp_err && model_cause == 2'd0) begin
          model_cause = (slot < 0) ? 2'd1 : 2'd2;
          model_addr  = addr;
        end
        check("err_cause", 64'(err_cause_o), 64'(model_cause));
        check("err_addr", 64'(err_addr_o), 64'(model_addr));
`endif
      end
    end
    check("done_reached", 64'(done), 64'd1);
    slv_ready = '0;
  endtask

  initial begin
    int          pick;
    int          dly;
    logic [31:0] addr;
    logic [7:0]  tops [6];

    tops = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h07, 8'hFF};
    resetn = 1'b0; core_req = 1'b0; core_we = 1'b0; core_size = '0;
    core_addr = '0; core_wd = '0; slv_rd = '0; slv_ready = '0;
`ifdef SYS_BUS_ERR_CAUSE_EN
    err_clr = 1'b0; model_cause = '0; model_addr = '0;
`endif

    // Reset state.
    #12;
    check("rst_stall", 64'(core_stall_o), 64'd0);
    check("rst_req", 64'(slv_req_o), 64'd0);
    check("rst_rd", 64'(core_rd_o), 64'd0);
    check("rst_err", 64'(bus_err_o), 64'd0);
    check("rst_addr", 64'(slv_addr_o), 64'd0);
    check("rst_wd", 64'(slv_wd_o), 64'd0);
`ifdef SYS_BUS_ERR_CAUSE_EN
    check("rst_cause", 64'(err_cause_o), 64'd0);
`endif
    @(negedge clk); resetn = 1'b1;

    // Directed scenarios.
    txn(32'h0300_0010, 1'b0, 3'd2, 32'h0, 1, 32'hCAFE_0001, 1'b0);
    txn(32'h0400_0004, 1'b1, 3'd2, 32'h0000_1234, 0, 32'hDEAD_BEEF, 1'b0);
    txn(32'h0700_0000, 1'b0, 3'd2, 32'h0, 0, 32'h0, 1'b0);
    txn(32'h0000_0100, 1'b0, 3'd2, 32'h0, -1, 32'h0, 1'b0);
    txn(32'h0200_0000, 1'b0, 3'd1, 32'h0, TMO - 1, 32'hA5A5_5A5A, 1'b1);

`ifdef SYS_BUS_ERR_CAUSE_EN
    // Clear the sticky record, then a timeout is the first error again.
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    check("clr_cause", 64'(err_cause_o), 64'd0);
    check("clr_addr", 64'(err_addr_o), 64'd0);
    model_cause = '0; model_addr = '0;
    txn(32'h0000_0200, 1'b0, 3'd2, 32'h0, -1, 32'h0, 1'b0);
`endif

    // Reset in the middle of WAIT.
    @(negedge clk);
    core_req = 1'b1; core_addr = 32'h0200_0040; core_we = 1'b0;
    @(negedge clk); core_req = 1'b0;
    @(negedge clk);
    @(negedge clk); resetn = 1'b0;
    #1;
    check("midrst_req", 64'(slv_req_o), 64'd0);
    check("midrst_stall", 64'(core_stall_o), 64'd0);
    check("midrst_err", 64'(bus_err_o), 64'd0);
`ifdef SYS_BUS_ERR_CAUSE_EN
    model_cause = '0; model_addr = '0;
`endif
    @(negedge clk); resetn = 1'b1;
    txn(32'h0300_0080, 1'b0, 3'd2, 32'h0, 2, 32'h1357_9BDF, 1'b0);

    // Random transactions.
    for (int t = 0; t < 40; t++) begin
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[31:24] = tops[$urandom_range(0, 5)];
      pick = int'($urandom_range(0, 9));
      if (pick <= 5)      dly = pick % 4;
      else if (pick == 6) dly = TMO - 1;
      else if (pick == 7) dly = TMO;
      else if (pick == 8) dly = -1;
      else                dly = int'($urandom_range(0, TMO + 2));
      txn(addr, 1'($urandom), 3'($urandom), $urandom, dly, $urandom, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
